// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv block (mult_module and div_module).
//   DIVIDEND_W / DIVISOR_W : default operand widths for the divider
//   RDY_ON / RDY_OFF       : handshake levels shared by inputRDY/resultRDY
//   div_state_t            : divider FSM states
package multdiv_pkg;
  localparam int   DIVIDEND_W = 32;
  localparam int   DIVISOR_W  = 16;

  localparam logic RDY_ON  = 1'b1;
  localparam logic RDY_OFF = 1'b0;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step (combinational).
//   rem      : partial remainder (DIVISOR_W+1 bits)
//   quo      : dividend/quotient shift register
//   divisor  : divisor magnitude (DIVISOR_W+1 bits)
//   rem_next : remainder after shifting in quo's MSB and conditional subtract
//   quo_next : quo shifted left with the new quotient bit in bit 0
module div_step #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic [DIVISOR_W:0]    rem,
  input  logic [DIVIDEND_W-1:0] quo,
  input  logic [DIVISOR_W:0]    divisor,
  output logic [DIVISOR_W:0]    rem_next,
  output logic [DIVIDEND_W-1:0] quo_next
);
  localparam int REM_W = DIVISOR_W + 1;

  // One extra bit so the shifted value and the difference cannot wrap.
  logic [REM_W:0] shifted;
  logic [REM_W:0] diff;
  logic           ge;

  assign shifted  = {rem, quo[DIVIDEND_W-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign ge       = shifted >= {1'b0, divisor};
  assign rem_next = REM_W'(ge ? diff : shifted);
  assign quo_next = {quo[DIVIDEND_W-2:0], ge};
endmodule

// File: rtl/div_module.sv
// Sequential signed divider, one quotient bit per clock.
//   clock          : clock, all state on posedge
//   reset_n        : synchronous active-low reset (aborts any division)
//   data_operandA  : dividend, two's complement
//   data_operandB  : divisor, two's complement
//   ctrl_DIV       : start; only honoured while data_inputRDY=1
//   data_result    : quotient truncated toward zero (held until next result)
//   data_exception : divide-by-zero or -2^(W-1)/-1 overflow
//   data_inputRDY  : idle, will accept ctrl_DIV this cycle
//   data_resultRDY : one-cycle pulse, data_result/data_exception valid
module div_module #(
  parameter int DIVIDEND_W = multdiv_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = multdiv_pkg::DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DIVIDEND_W-1:0] data_operandA,
  input  logic [DIVISOR_W-1:0]  data_operandB,
  input  logic                  ctrl_DIV,
  output logic [DIVIDEND_W-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_inputRDY,
  output logic                  data_resultRDY
);
  import multdiv_pkg::*;

  localparam int REM_W = DIVISOR_W + 1;
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t            state, state_nxt;
  logic [CNT_W-1:0]      count;
  logic                  sign;
  logic [REM_W-1:0]      rem, dvsr, rem_next;
  logic [DIVIDEND_W-1:0] quo, quo_next;

  logic [DIVIDEND_W-1:0] a_mag;
  logic [REM_W-1:0]      b_ext, b_mag;
  logic                  accept, div_zero, div_ovf, last_iter;

  assign accept    = (state == IDLE) && ctrl_DIV;
  // |A| fits unsigned even for the most negative dividend.
  assign a_mag     = data_operandA[DIVIDEND_W-1] ? -data_operandA : data_operandA;
  // Divisor sign-extended by one bit so |-2^(DW-1)| is representable.
  assign b_ext     = {data_operandB[DIVISOR_W-1], data_operandB};
  assign b_mag     = b_ext[REM_W-1] ? -b_ext : b_ext;
  assign div_zero  = (data_operandB == '0);
  assign div_ovf   = (data_operandA == {1'b1, {(DIVIDEND_W-1){1'b0}}}) && (data_operandB == '1);
  assign last_iter = (count == CNT_W'(DIVIDEND_W - 1));

  div_step #(.DIVIDEND_W(DIVIDEND_W), .DIVISOR_W(DIVISOR_W)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ctrl_DIV) state_nxt = (div_zero || div_ovf) ? DONE : ITER;
      ITER: if (last_iter) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    data_inputRDY  = (state == IDLE) ? RDY_ON : RDY_OFF;
    data_resultRDY = (state == DONE) ? RDY_ON : RDY_OFF;
  end

  // Datapath
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count          <= '0;
      sign           <= 1'b0;
      rem            <= '0;
      dvsr           <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          count <= '0;
          sign  <= data_operandA[DIVIDEND_W-1] ^ data_operandB[DIVISOR_W-1];
          rem   <= '0;
          quo   <= a_mag;
          dvsr  <= b_mag;
          // Exceptions complete straight away; normal results land in FIX.
          if (div_zero || div_ovf) begin
            data_result    <= '0;
            data_exception <= 1'b1;
          end
        end
        ITER: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 1'b1;
        end
        FIX: begin
          data_result    <= sign ? -quo : quo;
          data_exception <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_module.sv
// Scoreboarded bench for div_module: directed corner cases then random ops.
module tb_div_module;
  localparam int AW = 32;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [15:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception, data_inputRDY, data_resultRDY;

  div_module dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Edge counter: after active edge N, cyc == N.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;   // cyc value while resultRDY must be high
  } exp_t;

  exp_t        sbq[$];
  int          compared = 0, mismatched = 0;
  int          t_acc = 0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed integer division truncating toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.due = 0;
    if (sb == 0 || (sa == -64'sd2147483648 && sb == -1)) begin
      e.res = '0;
      e.exc = 1'b1;
    end else begin
      e.res = 32'(sa / sb);
      e.exc = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every resultRDY pulse must match the oldest outstanding op.
  always @(negedge clock) begin
    if (data_resultRDY === 1'b1) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resultRDY: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", 64'(data_result), 64'(e.res));
        check("exception", 64'(data_exception), 64'(e.exc));
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  function automatic void push_exp(input logic [31:0] a, input logic [15:0] b);
    exp_t e;
    e = model(a, b);
    // resultRDY is high in the cycle ending at edge T+1 (exception) or T+AW+2.
    e.due = cyc + (e.exc ? 1 : AW + 2) - 1;
    sbq.push_back(e);
    last_res = e.res;
    last_exc = e.exc;
    t_acc    = cyc;
  endfunction

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (data_inputRDY === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: got inputRDY=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] b);
    wait_ready();
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    push_exp(a, b);
    @(negedge clock);
    check("inputRDY_drop", 64'(data_inputRDY), 64'(0));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (sbq.size() == 0 && data_inputRDY === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: got %0d outstanding expected 0", sbq.size());
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [15:0] b);
    issue(a, b);
    wait_idle();
    repeat (2) @(negedge clock);
    check("hold_result", 64'(data_result), 64'(last_res));
    check("hold_exception", 64'(data_exception), 64'(last_exc));
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_result", 64'(data_result), 64'(0));
    check("rst_exception", 64'(data_exception), 64'(0));
    check("rst_resultRDY", 64'(data_resultRDY), 64'(0));
    check("rst_inputRDY", 64'(data_inputRDY), 64'(1));
    reset_n = 1'b1;

    run(32'd100, 16'd7);
    run(32'hFFFF_FF9C, 16'd7);       // -100 / 7
    run(32'd100, 16'hFFF9);          // 100 / -7
    run(32'hFFFF_FF9C, 16'hFFF9);    // -100 / -7

    // Divide by zero: pulse at T+1, ready again at T+2.
    issue(32'd7, 16'd0);
    @(negedge clock);
    check("exc_inputRDY_back", 64'(data_inputRDY), 64'(1));
    wait_idle();

    run(32'h8000_0000, 16'hFFFF);
    run(32'h8000_0000, 16'd2);
    run(32'h8000_0000, 16'h8000);

    // Start pulse mid-operation must be ignored.
    issue(32'd100, 16'd7);
    while (cyc != t_acc + 4) @(negedge clock);
    data_operandA = 32'd999;
    data_operandB = 16'd3;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    check("busy_inputRDY", 64'(data_inputRDY), 64'(0));
    wait_idle();

    // ctrl_DIV held through DONE: second accept only after IDLE returns.
    wait_ready();
    data_operandA = 32'd7;
    data_operandB = 16'd0;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    push_exp(32'd7, 16'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    push_exp(32'd7, 16'd0);
    ctrl_DIV = 1'b0;
    wait_idle();

    // Reset mid-operation aborts without a result.
    issue(32'd1000, 16'd3);
    while (cyc != t_acc + 9) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    sbq.delete();
    @(negedge clock);
    check("abort_result", 64'(data_result), 64'(0));
    check("abort_exception", 64'(data_exception), 64'(0));
    check("abort_resultRDY", 64'(data_resultRDY), 64'(0));
    check("abort_inputRDY", 64'(data_inputRDY), 64'(1));
    reset_n = 1'b1;
    repeat (40) @(negedge clock);
    run(32'd50, 16'd5);

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 16'h0000;
        1:       rb = 16'hFFFF;
        2:       rb = 16'h8000;
        3:       rb = 16'h0001;
        4:       rb = 16'($urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run(ra, rb);
    end

    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
